// File: rtl/aes_sub_bytes_engine_pkg.sv
// AES SubBytes engine: shared state type, FSM encoding and
// the FIPS-197 forward/inverse S-box tables.
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sub_bytes_state_e;

    localparam logic [7:0] SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] sbox_lookup(
        input logic [7:0] b,
        input logic       inverse
    );
        return inverse ? SBOX_INV[b] : SBOX_FWD[b];
    endfunction

endpackage

// File: rtl/aes_sub_bytes_engine_if.sv
// Block-in / block-out handshake bundle for the SubBytes engine.
interface aes_sub_bytes_engine_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t in_data;
    logic [15:0] in_byte_mask;
    logic       in_inverse;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_data;
    logic       busy;

    modport master (
        output in_valid, in_data, in_byte_mask, in_inverse, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_byte_mask, in_inverse, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/aes_sub_bytes_engine_sbox_lane.sv
// One combinational S-box lane, forward or inverse by select.
module aes_sbox_lane
    import aes_pkg::*;
(
    input  logic [7:0] data,
    input  logic       inverse,
    output logic [7:0] result
);

    assign result = sbox_lookup(data, inverse);

endmodule

// File: rtl/aes_sub_bytes_engine.sv
// Time-multiplexed AES SubBytes: LANES S-boxes sweep the 16
// state bytes over 16/LANES cycles, result held until taken.
module aes_sub_bytes_engine
    import aes_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int OUT_REG = 1
) (
    input logic clk,
    input logic reset,
    aes_sub_bytes_engine_if.slave bus
);

    localparam int N  = 16 / LANES;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 &&
        LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    if (OUT_REG != 1) begin : g_bad_out_reg
        $error("aes_sub_bytes_engine: OUT_REG must be 1");
    end

    sub_bytes_state_e state_q, state_d;

    logic [IW-1:0] idx_q;
    aes_state_t    src_q;
    aes_state_t    res_q;
    aes_state_t    res_d;
    aes_state_t    out_q;
    logic [15:0]   mask_q;
    logic          inv_q;
    logic          accept;
    logic          last;

    logic [3:0] lane_idx [LANES];
    logic [7:0] lane_out [LANES];
    logic [7:0] lane_res [LANES];

    // Lane k always owns byte idx*LANES+k of the current sweep
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_idx[k] = 4'(int'(idx_q) * LANES + k);

        aes_sbox_lane u_lane (
            .data    (src_q[{lane_idx[k], 3'b000} +: 8]),
            .inverse (inv_q),
            .result  (lane_out[k])
        );

        assign lane_res[k] = mask_q[lane_idx[k]] ? lane_out[k] : 8'h00;
    end

    always_comb begin
        res_d = res_q;
        for (int k = 0; k < LANES; k++) begin
            res_d[{lane_idx[k], 3'b000} +: 8] = lane_res[k];
        end
    end

    assign last = (idx_q == IDX_LAST);

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    accept  = bus.in_valid;
                    state_d = bus.in_valid ? BUSY : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            src_q   <= '0;
            mask_q  <= '0;
            inv_q   <= 1'b0;
            res_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                src_q  <= bus.in_data;
                mask_q <= bus.in_byte_mask;
                inv_q  <= bus.in_inverse;
                idx_q  <= '0;
            end else if (state_q == BUSY) begin
                res_q <= res_d;
                idx_q <= last ? '0 : idx_q + IW'(1);
                if (last) begin
                    out_q <= res_d;
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE) |
                           ((state_q == DONE) & bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = out_q;
    assign bus.busy      = (state_q == BUSY);

endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// Directed bench for aes_sub_bytes_engine across all LANES widths;
// one engine instance per width, selected by sel.
module tb_aes_sub_bytes_engine;
    import aes_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       inverse;
    logic       out_ready;
    aes_state_t in_data;
    logic [15:0] mask;
    logic [2:0] sel;

    logic       ir, ov, bz;
    aes_state_t od;

    logic       ir_v [5];
    logic       ov_v [5];
    logic       bz_v [5];
    aes_state_t od_v [5];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aes_sub_bytes_engine_if bus [5] ();

    for (genvar g = 0; g < 5; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : (g == 1) ? 16 :
                           (g == 2) ? 1 : (g == 3) ? 2 : 8;

        assign bus[g].in_valid     = in_valid && (sel == 3'(g));
        assign bus[g].in_data      = in_data;
        assign bus[g].in_byte_mask = mask;
        assign bus[g].in_inverse   = inverse;
        assign bus[g].out_ready    = out_ready;
        assign ir_v[g] = bus[g].in_ready;
        assign ov_v[g] = bus[g].out_valid;
        assign bz_v[g] = bus[g].busy;
        assign od_v[g] = bus[g].out_data;

        aes_sub_bytes_engine #(
            .LANES   (L),
            .OUT_REG (1)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus[g])
        );
    end

    always_comb begin
        ir = ir_v[sel];
        ov = ov_v[sel];
        bz = bz_v[sel];
        od = od_v[sel];
    end

    function automatic aes_state_t ref_sub(
        input aes_state_t d,
        input logic [15:0] m,
        input logic inv
    );
        aes_state_t r;
        logic [7:0] b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = d[8*i +: 8];
            if (m[i]) r[8*i +: 8] = inv ? SBOX_INV[b] : SBOX_FWD[b];
        end
        return r;
    endfunction

    task automatic wait_done(input int limit, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!ov && lat < limit);
    endtask

    task automatic run_block(
        input aes_state_t d, input logic [15:0] m, input logic inv,
        output int lat, output aes_state_t res
    );
        @(negedge clk);
        in_valid = 1'b1;
        in_data = d;
        mask = m;
        inverse = inv;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = {4{32'hdeadbeef}};
        mask = 16'h0;
        inverse = ~inv;
        wait_done(40, lat);
        checks++;
        if (ov !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: out_valid=%b after %0d cycles, need 1", ov, lat);
        end
        res = od;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        mask = 16'hffff;
        inverse = 1'b0;
        sel = 3'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 5; g++) begin
            checks++;
            if (ir_v[g] !== 1'b1 || ov_v[g] !== 1'b0 ||
                bz_v[g] !== 1'b0 || od_v[g] !== '0) begin
                errors++;
                $display("FAIL reset_dut%0d: ir=%b ov=%b busy=%b od=%h, need 1 0 0 0",
                         g, ir_v[g], ov_v[g], bz_v[g], od_v[g]);
            end
        end
    endtask

    task automatic test_forward();
        int lat;
        aes_state_t res;
        aes_state_t exp_v;
        sel = 3'd0;
        exp_v = {{12{8'h63}}, 32'hae1127d4};
        run_block({96'h0, 32'hbee33d19}, 16'hffff, 1'b0, lat, res);
        checks++;
        if (res !== exp_v) begin
            errors++;
            $display("FAIL fwd_data: got %h want %h", res, exp_v);
        end
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL fwd_latency: got %0d want 4", lat);
        end
    endtask

    task automatic test_inverse();
        int lat;
        aes_state_t res;
        sel = 3'd1;
        run_block({{12{8'h63}}, 32'hae1127d4}, 16'hffff, 1'b1, lat, res);
        checks++;
        if (res !== {96'h0, 32'hbee33d19}) begin
            errors++;
            $display("FAIL inv_data: got %h want %h", res, {96'h0, 32'hbee33d19});
        end
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL inv_latency: got %0d want 1", lat);
        end
    endtask

    task automatic test_mask();
        int lat;
        aes_state_t res;
        aes_state_t exp_v;
        sel = 3'd2;
        exp_v = {64'h0, {8{8'hed}}};
        run_block({16{8'h53}}, 16'h00ff, 1'b0, lat, res);
        checks++;
        if (res !== exp_v) begin
            errors++;
            $display("FAIL mask_data: got %h want %h", res, exp_v);
        end
        checks++;
        if (lat != 16) begin
            errors++;
            $display("FAIL mask_latency: got %0d want 16", lat);
        end
    endtask

    task automatic test_reset_busy();
        logic seen;
        sel = 3'd0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 128'h00112233445566778899aabbccddeeff;
        mask = 16'hffff;
        inverse = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bz !== 1'b1 || ir !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_pre: busy=%b ir=%b, need 1 0", bz, ir);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ir !== 1'b1 || ov !== 1'b0 || bz !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy_ctl: ir=%b ov=%b busy=%b, need 1 0 0", ir, ov, bz);
        end
        checks++;
        if (od !== '0) begin
            errors++;
            $display("FAIL rst_busy_data: got %h want 0", od);
        end
        seen = 1'b0;
        out_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ov) seen = 1'b1;
        end
        out_ready = 1'b0;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_output: out_valid seen=%b want 0", seen);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic stable;
        aes_state_t exp_a;
        aes_state_t exp_b;
        sel = 3'd3;
        exp_a = 128'h638293c31bfc33f5c4eeacea4bc12816;
        exp_b = {16{8'hed}};
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 128'h00112233445566778899aabbccddeeff;
        mask = 16'hffff;
        inverse = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_data = {16{8'h53}};
        wait_done(40, lat);
        checks++;
        if (lat != 8 || ov !== 1'b1) begin
            errors++;
            $display("FAIL bp_latency: got %0d ov=%b want 8 1", lat, ov);
        end
        checks++;
        if (od !== exp_a) begin
            errors++;
            $display("FAIL bp_data_a: got %h want %h", od, exp_a);
        end
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (ov !== 1'b1 || od !== exp_a || ir !== 1'b0 || bz !== 1'b0)
                stable = 1'b0;
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: got stable=%b want 1", stable);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (ir !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_comb: got %b want 1", ir);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_data = '0;
        @(negedge clk);
        checks++;
        if (bz !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL bp_same_edge: busy=%b ov=%b want 1 0", bz, ov);
        end
        wait_done(40, lat);
        checks++;
        if (lat != 8 || od !== exp_b) begin
            errors++;
            $display("FAIL bp_data_b: got %h lat %0d want %h lat 8", od, lat, exp_b);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        aes_state_t blk [5];
        logic [15:0] msk [5];
        logic iv [5];
        aes_state_t q [$];
        int nin, nout, cyc, last_cyc;
        logic acc;
        sel = 3'd4;
        for (int i = 0; i < 5; i++) begin
            blk[i] = {$urandom, $urandom, $urandom, $urandom};
            msk[i] = 16'($urandom);
            iv[i] = 1'($urandom_range(0, 1));
        end
        nin = 0;
        nout = 0;
        cyc = 0;
        last_cyc = -1;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = blk[0];
        mask = msk[0];
        inverse = iv[0];
        while (nout < 5 && cyc < 80) begin
            if (ov) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected: got %h want none", od);
                end else begin
                    if (od !== q[0]) begin
                        errors++;
                        $display("FAIL b2b_data%0d: got %h want %h", nout, od, q[0]);
                    end
                    void'(q.pop_front());
                end
                if (nout > 0) begin
                    checks++;
                    if (cyc - last_cyc != 3) begin
                        errors++;
                        $display("FAIL b2b_rate: got %0d want 3", cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                nout++;
            end
            acc = in_valid && ir;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                q.push_back(ref_sub(blk[nin], msk[nin], iv[nin]));
                nin++;
                if (nin < 5) begin
                    in_data = blk[nin];
                    mask = msk[nin];
                    inverse = iv[nin];
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (nout != 5) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 5", nout);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_mask();
        test_reset_busy();
        test_backpressure();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_sub_bytes_engine.md
# aes_sub_bytes_engine

Parametrised, sequential AES SubBytes engine: accepts a 128-bit AES state over a valid/ready handshake, substitutes every byte through the forward or inverse AES S-box, and returns the 128-bit result over a second valid/ready handshake. It replaces the flat combinational byte-lookup matrix with a time-multiplexed datapath of `LANES` S-box instances. It sits between AddRoundKey and ShiftRows in the encryption round, and between InvShiftRows and AddRoundKey in the decryption round.

## Interface
- `LANES`, 4: bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
- `OUT_REG`, 1: 1 registers `out_data` at DONE entry; 0 is reserved and is an elaboration error in this revision.
- `clk`  in  1  single clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  input block present.
- `in_ready`  out  1  engine can accept a block.
- `in_data`  in  128  state; byte i = `in_data[8*i+7:8*i]`.
- `in_byte_mask`  in  16  bit i=1 substitutes byte i; bit i=0 forces output byte i to 0x00.
- `in_inverse`  in  1  0 selects the forward S-box, 1 selects the inverse S-box.
- `out_valid`  out  1  result block present.
- `out_ready`  in  1  consumer accepts result.
- `out_data`  out  128  substituted state, same byte order as `in_data`.
- `busy`  out  1  high in BUSY.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: `in_ready`=1. On `in_valid`: latch `in_data`, `in_byte_mask` and `in_inverse`; clear `idx`; go to BUSY.
- BUSY: each cycle, lanes k=0..LANES-1 process byte `idx*LANES+k`.
  - Masked-in byte: write the S-box result (fwd or inv per latched mode) into the result register.
  - Masked-out byte: write 0x00.
- `idx` is a counter of width clog2(16/LANES), minimum 1 bit. It increments each BUSY cycle. When `idx` = 16/LANES-1 the FSM goes to DONE and `idx` wraps to 0.
- DONE: `out_valid`=1, with `out_data` stable until the handshake.
  - On `out_ready` with no `in_valid`: go to IDLE.
  - On `out_ready` and `in_valid` in the same cycle: latch the new block and go directly to BUSY.
- `in_ready` = (state==IDLE) | (state==DONE & out_ready). In BUSY, or in DONE without `out_ready`, `in_ready` is 0 and inputs are ignored.
- Input changes after the accept edge have no effect on the block in flight.
- Reset in any state: go to IDLE, discard the block in flight, clear `idx` and `out_data`. No output handshake occurs for the discarded block.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `busy`=0, `out_data`=0.
- Latency: `out_valid` rises N=16/LANES cycles after the accept edge. LANES=16 gives 1 cycle; LANES=1 gives 16 cycles.
- Throughput: one block per N+1 cycles under continuous `in_valid` and `out_ready`.
- With `out_ready` held low, DONE holds indefinitely and `out_data` does not change.
- `in_ready` has a combinational path from `out_ready`. No combinational path exists from `in_valid` to any output.

## Structure
- Package `aes_pkg`:
  - `localparam logic [7:0] SBOX_FWD[256]` and `SBOX_INV[256]` (FIPS-197 tables).
  - typedef `aes_state_t` (logic [127:0]).
  - enum `sub_bytes_state_e` {IDLE, BUSY, DONE}.
- Sub-module `aes_sbox_lane`: combinational 8-bit in, `inverse` select, 8-bit out. Instantiated LANES times via a generate loop.

## Test plan
- Reset, LANES=4: assert `reset` during BUSY after 2 cycles -> next cycle `in_ready`=1, `out_valid`=0, `out_data`=0, and no output handshake occurs.
- Forward, LANES=4, mask 0xFFFF, `in_data` bytes 0..3 = 0x19, 0x3d, 0xe3, 0xbe, rest 0x00 -> output bytes 0..3 = 0xd4, 0x27, 0x11, 0xae, rest 0x63; `out_valid` 4 cycles after accept.
- Inverse round-trip, LANES=16: feed the previous output with `in_inverse`=1 -> original block returned; `out_valid` 1 cycle after accept.
- Mask, LANES=1: all bytes 0x53, mask 0x00FF -> bytes 0..7 = 0xED, bytes 8..15 = 0x00; latency 16 cycles.
- Backpressure, LANES=2: hold `out_ready`=0 for 10 cycles -> `out_valid` and `out_data` stable, `in_ready`=0. Release `out_ready` with `in_valid` high -> new block accepted on the same edge.
- Back-to-back, LANES=8: 5 random blocks with a scoreboard against the `aes_pkg` tables -> all match, one block per 3 cycles.
